// File: rtl/mgt_link_watchdog.sv
// ---------------------------------------------------------------------------
// mgt_link_watchdog
//
// Supervises a running MGT transmitter once its startup sequence has
// finished. A persistent loss of TX PLL lock or of any TX-reset-done bit
// triggers escalating recovery: first a TX reset pulse, then a per-channel
// MGT reset pulse aimed at the channels that are not done. Each failed
// round (TX reset followed by MGT reset) bumps a saturating retry counter,
// and once the counter reaches MAX_RETRIES the watchdog parks in GIVEUP
// until software pulses clear_i.
//
// Ports:
//   clock_40          in   1  sole clock, rising edge
//   reset_n_i         in   1  asynchronous active-low reset
//   enable_i          in   1  watchdog enable, low forces IDLE
//   clear_i           in   1  single-cycle pulse: zero retries, leave GIVEUP
//   ready_i           in   1  ready output of the MGT control block
//   pll_lock_i        in   1  TX PLL lock, already synchronous to clock_40
//   txresetdone_i     in   4  per-channel TX reset done
//   ext_txreset_o     out  1  TX reset request to the MGT control block
//   ext_mgt_reset_o   out  4  per-channel MGT reset request
//   force_not_ready_o out  1  holds the control block's ready timer cleared
//   retry_cnt_o       out  4  completed failed rounds, saturating at 15
//   gave_up_o         out  1  high while in GIVEUP
//   state_o           out  3  current state encoding
// ---------------------------------------------------------------------------
module mgt_link_watchdog #(
   parameter int unsigned FAULT_FILTER   = 8,
   parameter int unsigned TXRESET_PULSE  = 16,
   parameter int unsigned MGTRESET_PULSE = 64,
   parameter int unsigned SETTLE_CNT     = 4000,
   parameter int unsigned MAX_RETRIES    = 7
) (
   input  logic       clock_40,
   input  logic       reset_n_i,
   input  logic       enable_i,
   input  logic       clear_i,
   input  logic       ready_i,
   input  logic       pll_lock_i,
   input  logic [3:0] txresetdone_i,
   output logic       ext_txreset_o,
   output logic [3:0] ext_mgt_reset_o,
   output logic       force_not_ready_o,
   output logic [3:0] retry_cnt_o,
   output logic       gave_up_o,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_MONITOR    = 3'd1,
      ST_TXRESET    = 3'd2,
      ST_TX_SETTLE  = 3'd3,
      ST_MGTRESET   = 3'd4,
      ST_MGT_SETTLE = 3'd5,
      ST_GIVEUP     = 3'd6
   } state_t;

   // One shared down-counter serves every pulse and settle phase, so it is
   // sized for the longest of them. It only ever holds (length - 1).
   localparam int unsigned CNT_MAX_A = (TXRESET_PULSE > MGTRESET_PULSE) ?
                                       TXRESET_PULSE : MGTRESET_PULSE;
   localparam int unsigned CNT_MAX   = (CNT_MAX_A > SETTLE_CNT) ? CNT_MAX_A : SETTLE_CNT;
   localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
   localparam int unsigned FILT_W    = $clog2(FAULT_FILTER + 1);

   localparam logic [CNT_W-1:0]  TXP_LOAD    = CNT_W'(TXRESET_PULSE - 1);
   localparam logic [CNT_W-1:0]  MGP_LOAD    = CNT_W'(MGTRESET_PULSE - 1);
   localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CNT - 1);
   localparam logic [FILT_W-1:0] FILT_LIMIT  = FILT_W'(FAULT_FILTER);
   localparam logic [3:0]        RETRY_LIMIT = 4'(MAX_RETRIES);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [FILT_W-1:0] filt_q, filt_d;
   logic [3:0]        mask_q, mask_d;
   logic [3:0]        retry_q, retry_d;
   logic              ext_txreset_q, ext_txreset_d;
   logic [3:0]        ext_mgt_reset_q, ext_mgt_reset_d;
   logic              force_not_ready_q, force_not_ready_d;
   logic              gave_up_q, gave_up_d;

   logic              fault;
   logic [3:0]        not_done;
   logic [3:0]        retry_inc;
   logic [3:0]        retry_fail;

   assign fault    = ~pll_lock_i | ~&txresetdone_i;
   assign not_done = ~txresetdone_i;

   // Value the retry counter takes after a failed round. A coincident clear
   // wins, and the give-up decision is made on this post-clear value so a
   // clear on the failing sample always sends us round again.
   assign retry_inc  = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
   assign retry_fail = clear_i ? 4'd0 : retry_inc;

   // Next-state logic. Each timed phase loads its count on entry and leaves
   // when the count reaches zero, so a phase lasts exactly its parameter.
   // Outputs are derived from the next state so that they register in step
   // with state_q.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      filt_d   = '0;
      mask_d   = mask_q;
      retry_d  = retry_q;

      unique case (state_q)
         ST_IDLE: begin
            if (enable_i && ready_i) begin
               state_d = ST_MONITOR;
            end
         end

         // The filter must see FAULT_FILTER consecutive faulty samples; any
         // clean sample restarts it.
         ST_MONITOR: begin
            if (filt_q == FILT_LIMIT) begin
               state_d = ST_TXRESET;
               cnt_d   = TXP_LOAD;
            end else begin
               filt_d = fault ? filt_q + FILT_W'(1) : '0;
            end
         end

         ST_TXRESET: begin
            if (cnt_q == '0) begin
               state_d = ST_TX_SETTLE;
               cnt_d   = SETTLE_LOAD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         // A fault with every channel reporting done can only be the PLL, in
         // which case all channels get the MGT reset.
         ST_TX_SETTLE: begin
            if (cnt_q == '0) begin
               if (fault) begin
                  state_d = ST_MGTRESET;
                  cnt_d   = MGP_LOAD;
                  mask_d  = (not_done == 4'h0) ? 4'hF : not_done;
               end else begin
                  state_d = ST_MONITOR;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         ST_MGTRESET: begin
            if (cnt_q == '0) begin
               state_d = ST_MGT_SETTLE;
               cnt_d   = SETTLE_LOAD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         ST_MGT_SETTLE: begin
            if (cnt_q == '0) begin
               if (fault) begin
                  retry_d = retry_fail;
                  if (retry_fail >= RETRY_LIMIT) begin
                     state_d = ST_GIVEUP;
                  end else begin
                     state_d = ST_TXRESET;
                     cnt_d   = TXP_LOAD;
                  end
               end else begin
                  state_d = ST_MONITOR;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         ST_GIVEUP: begin
            if (clear_i) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (clear_i) begin
         retry_d = 4'd0;
      end

      // Disabling overrides every transition; the retry count survives.
      if (!enable_i) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         filt_d  = '0;
      end

      ext_txreset_d     = (state_d == ST_TXRESET);
      ext_mgt_reset_d   = (state_d == ST_MGTRESET) ? mask_d : 4'h0;
      gave_up_d         = (state_d == ST_GIVEUP);
      force_not_ready_d = (state_d == ST_TXRESET)   || (state_d == ST_TX_SETTLE)  ||
                          (state_d == ST_MGTRESET)  || (state_d == ST_MGT_SETTLE) ||
                          (state_d == ST_GIVEUP);
   end

   // State, counters and registered outputs. The asynchronous reset clears
   // everything at once, which also cuts any pulse in progress.
   always_ff @(posedge clock_40 or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q           <= ST_IDLE;
         cnt_q             <= '0;
         filt_q            <= '0;
         mask_q            <= 4'h0;
         retry_q           <= 4'h0;
         ext_txreset_q     <= 1'b0;
         ext_mgt_reset_q   <= 4'h0;
         force_not_ready_q <= 1'b0;
         gave_up_q         <= 1'b0;
      end else begin
         state_q           <= state_d;
         cnt_q             <= cnt_d;
         filt_q            <= filt_d;
         mask_q            <= mask_d;
         retry_q           <= retry_d;
         ext_txreset_q     <= ext_txreset_d;
         ext_mgt_reset_q   <= ext_mgt_reset_d;
         force_not_ready_q <= force_not_ready_d;
         gave_up_q         <= gave_up_d;
      end
   end

   assign ext_txreset_o     = ext_txreset_q;
   assign ext_mgt_reset_o   = ext_mgt_reset_q;
   assign force_not_ready_o = force_not_ready_q;
   assign retry_cnt_o       = retry_q;
   assign gave_up_o         = gave_up_q;
   assign state_o           = state_q;

endmodule

// File: tb/tb_mgt_link_watchdog.sv
// ---------------------------------------------------------------------------
// tb_mgt_link_watchdog
//
// Directed bench for mgt_link_watchdog with short timing parameters
// (filter 4, TX pulse 3, MGT pulse 5, settle 10, max retries 2). Inputs are
// driven and outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_mgt_link_watchdog;

   logic       clock_40 = 1'b0;
   logic       reset_n_i;
   logic       enable_i;
   logic       clear_i;
   logic       ready_i;
   logic       pll_lock_i;
   logic [3:0] txresetdone_i;
   logic       ext_txreset_o;
   logic [3:0] ext_mgt_reset_o;
   logic       force_not_ready_o;
   logic [3:0] retry_cnt_o;
   logic       gave_up_o;
   logic [2:0] state_o;

   int checks = 0;
   int errors = 0;

   mgt_link_watchdog #(
      .FAULT_FILTER  (4),
      .TXRESET_PULSE (3),
      .MGTRESET_PULSE(5),
      .SETTLE_CNT    (10),
      .MAX_RETRIES   (2)
   ) dut (
      .clock_40         (clock_40),
      .reset_n_i        (reset_n_i),
      .enable_i         (enable_i),
      .clear_i          (clear_i),
      .ready_i          (ready_i),
      .pll_lock_i       (pll_lock_i),
      .txresetdone_i    (txresetdone_i),
      .ext_txreset_o    (ext_txreset_o),
      .ext_mgt_reset_o  (ext_mgt_reset_o),
      .force_not_ready_o(force_not_ready_o),
      .retry_cnt_o      (retry_cnt_o),
      .gave_up_o        (gave_up_o),
      .state_o          (state_o)
   );

   always #5 clock_40 = ~clock_40;

   // Drive all functional inputs at once.
   task automatic applyStimulus(input logic en, input logic rdy, input logic lock,
                                input logic [3:0] done, input logic clr);
      enable_i      = en;
      ready_i       = rdy;
      pll_lock_i    = lock;
      txresetdone_i = done;
      clear_i       = clr;
   endtask

   // Advance n rising edges and settle just past the last one.
   task automatic cycles(input int n);
      repeat (n) @(posedge clock_40);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Compare every output against a full expected vector.
   task automatic checkAll(input string tag, input logic [2:0] st, input logic txr,
                           input logic [3:0] mgt, input logic fnr,
                           input logic [3:0] retry, input logic gu);
      checkOutput({tag, ".state"},   8'(state_o),           8'(st));
      checkOutput({tag, ".txreset"}, 8'(ext_txreset_o),     8'(txr));
      checkOutput({tag, ".mgtrst"},  8'(ext_mgt_reset_o),   8'(mgt));
      checkOutput({tag, ".fnr"},     8'(force_not_ready_o), 8'(fnr));
      checkOutput({tag, ".retry"},   8'(retry_cnt_o),       8'(retry));
      checkOutput({tag, ".gaveup"},  8'(gave_up_o),         8'(gu));
   endtask

   // Guards against a stalled simulation.
   initial begin
      #200000;
      $display("[TB] FAIL timeout observed=running expected=finished");
      $fatal(1, "[TB] simulation time limit reached");
   end

   initial begin
      reset_n_i = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b1, 4'hF, 1'b0);
      cycles(3);
      checkAll("reset", 3'd0, 1'b0, 4'h0, 1'b0, 4'd0, 1'b0);

      // Release reset and enable with a healthy link.
      reset_n_i = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b1, 4'hF, 1'b0);
      cycles(1);
      checkAll("enter_monitor", 3'd1, 1'b0, 4'h0, 1'b0, 4'd0, 1'b0);

      // 1. Three faulty cycles are filtered out.
      applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, 1'b0);
      cycles(3);
      applyStimulus(1'b1, 1'b1, 1'b1, 4'hF, 1'b0);
      cycles(1);
      checkAll("short_fault", 3'd1, 1'b0, 4'h0, 1'b0, 4'd0, 1'b0);

      // Six faulty cycles: TX reset starts on the fifth edge.
      applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, 1'b0);
      cycles(4);
      checkAll("filter_edge4", 3'd1, 1'b0, 4'h0, 1'b0, 4'd0, 1'b0);
      cycles(1);
      checkAll("txreset_c1", 3'd2, 1'b1, 4'h0, 1'b1, 4'd0, 1'b0);
      cycles(1);
      applyStimulus(1'b1, 1'b1, 1'b1, 4'hF, 1'b0);
      checkAll("txreset_c2", 3'd2, 1'b1, 4'h0, 1'b1, 4'd0, 1'b0);
      cycles(1);
      checkAll("txreset_c3", 3'd2, 1'b1, 4'h0, 1'b1, 4'd0, 1'b0);
      cycles(1);
      checkAll("tx_settle_entry", 3'd3, 1'b0, 4'h0, 1'b1, 4'd0, 1'b0);
      cycles(9);
      checkAll("tx_settle_last", 3'd3, 1'b0, 4'h0, 1'b1, 4'd0, 1'b0);
      cycles(1);
      checkAll("tx_recovered", 3'd1, 1'b0, 4'h0, 1'b0, 4'd0, 1'b0);

      // 2. Channel 2 stuck not-done escalates to a masked MGT reset.
      applyStimulus(1'b1, 1'b1, 1'b1, 4'b1011, 1'b0);
      cycles(17);
      checkAll("mask_tx_settle", 3'd3, 1'b0, 4'h0, 1'b1, 4'd0, 1'b0);
      cycles(1);
      checkAll("mask_mgt_c1", 3'd4, 1'b0, 4'b0100, 1'b1, 4'd0, 1'b0);
      cycles(4);
      checkAll("mask_mgt_c5", 3'd4, 1'b0, 4'b0100, 1'b1, 4'd0, 1'b0);
      cycles(1);
      checkAll("mask_mgt_settle", 3'd5, 1'b0, 4'h0, 1'b1, 4'd0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 4'hF, 1'b0);
      cycles(9);
      checkAll("mask_settle_last", 3'd5, 1'b0, 4'h0, 1'b1, 4'd0, 1'b0);
      cycles(1);
      checkAll("mask_recovered", 3'd1, 1'b0, 4'h0, 1'b0, 4'd0, 1'b0);

      // 3. PLL-only fault resets every channel.
      applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, 1'b0);
      cycles(18);
      checkAll("pll_mgt_c1", 3'd4, 1'b0, 4'hF, 1'b1, 4'd0, 1'b0);
      cycles(4);
      checkAll("pll_mgt_c5", 3'd4, 1'b0, 4'hF, 1'b1, 4'd0, 1'b0);
      cycles(1);
      checkAll("pll_mgt_settle", 3'd5, 1'b0, 4'h0, 1'b1, 4'd0, 1'b0);

      // 4. Permanent fault: two failed rounds end in GIVEUP.
      cycles(10);
      checkAll("round1_failed", 3'd2, 1'b1, 4'h0, 1'b1, 4'd1, 1'b0);
      cycles(13);
      checkAll("round2_mgt", 3'd4, 1'b0, 4'hF, 1'b1, 4'd1, 1'b0);
      cycles(5);
      checkAll("round2_settle", 3'd5, 1'b0, 4'h0, 1'b1, 4'd1, 1'b0);
      cycles(10);
      checkAll("giveup", 3'd6, 1'b0, 4'h0, 1'b1, 4'd2, 1'b1);
      cycles(3);
      checkAll("giveup_hold", 3'd6, 1'b0, 4'h0, 1'b1, 4'd2, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, 1'b1);
      cycles(1);
      applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, 1'b0);
      checkAll("giveup_clear", 3'd0, 1'b0, 4'h0, 1'b0, 4'd0, 1'b0);

      // 5. One failed round, then disable in the 2nd MGT reset cycle.
      cycles(1);
      checkAll("re_monitor", 3'd1, 1'b0, 4'h0, 1'b0, 4'd0, 1'b0);
      cycles(33);
      checkAll("dis_round1", 3'd2, 1'b1, 4'h0, 1'b1, 4'd1, 1'b0);
      cycles(13);
      checkAll("dis_mgt_c1", 3'd4, 1'b0, 4'hF, 1'b1, 4'd1, 1'b0);
      cycles(1);
      applyStimulus(1'b0, 1'b1, 1'b0, 4'hF, 1'b0);
      cycles(1);
      checkAll("disabled", 3'd0, 1'b0, 4'h0, 1'b0, 4'd1, 1'b0);

      // 6. Clear coinciding with a failing MGT_SETTLE sample.
      applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, 1'b0);
      cycles(1);
      checkAll("sim_monitor", 3'd1, 1'b0, 4'h0, 1'b0, 4'd1, 1'b0);
      cycles(32);
      checkAll("sim_settle_last", 3'd5, 1'b0, 4'h0, 1'b1, 4'd1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, 1'b1);
      cycles(1);
      applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, 1'b0);
      checkAll("sim_clear_win", 3'd2, 1'b1, 4'h0, 1'b1, 4'd0, 1'b0);

      // Asynchronous reset in the middle of the TX reset pulse.
      cycles(1);
      checkAll("pre_async", 3'd2, 1'b1, 4'h0, 1'b1, 4'd0, 1'b0);
      #2;
      reset_n_i = 1'b0;
      #1;
      checkAll("async_reset", 3'd0, 1'b0, 4'h0, 1'b0, 4'd0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
